// File: rtl/afifo_pkg.sv
// Shared constants and pointer-code helpers for the dual-clock FIFO.
// Conversions work on a wide container so any pointer width up to PTR_MAX fits.
package afifo_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int AW            = $clog2(DEFAULT_DEPTH);
  localparam int PTR_MAX       = 32;

  typedef logic [PTR_MAX-1:0] ptr_t;

  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_gray_sync.sv
// Multi-flop synchronizer that carries one Gray-coded pointer into the destination clock domain.
module afifo_gray_sync #(
  parameter int WIDTH       = afifo_pkg::AW + 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo_level.sv
// Dual-clock FIFO: Gray pointers cross domains, full/empty and fill levels are registered per domain.
// The storage array has no reset; both domain resets must be asserted together to flush.
module async_fifo_level #(
  parameter  int WIDTH       = 8,
  parameter  int DEPTH       = afifo_pkg::DEFAULT_DEPTH,
  parameter  int SYNC_STAGES = 2,
  parameter  int AF_LEVEL    = DEPTH - 2,
  parameter  int AE_LEVEL    = 2,
  localparam int AW          = afifo_pkg::aw_of(DEPTH)
) (
  input  logic             wclk,
  input  logic             wrstn,
  input  logic             winc,
  input  logic [WIDTH-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  output logic [AW:0]      wlevel,
  output logic             woverflow,
  input  logic             rclk,
  input  logic             rrstn,
  input  logic             rinc,
  output logic [WIDTH-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [AW:0]      rlevel,
  output logic             runderflow
);

  import afifo_pkg::*;

  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, wlevel_q, wlevel_d;
  logic [PW-1:0] rgray_ws, rbin_ws;
  logic          wfull_q, wfull_d, walmost_full_q, walmost_full_d;
  logic          woverflow_q, woverflow_d, wpush;

  logic [PW-1:0]    rbin_q, rbin_d, rgray_q, rgray_d, rlevel_q, rlevel_d;
  logic [PW-1:0]    wgray_rs, wbin_rs;
  logic             rempty_q, rempty_d, ralmost_empty_q, ralmost_empty_d;
  logic             runderflow_q, runderflow_d, rpop;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  afifo_gray_sync #(.WIDTH(PW), .SYNC_STAGES(SYNC_STAGES)) u_r2w_sync (
    .clk (wclk),
    .rst (wrstn),
    .d   (rgray_q),
    .q   (rgray_ws)
  );

  afifo_gray_sync #(.WIDTH(PW), .SYNC_STAGES(SYNC_STAGES)) u_w2r_sync (
    .clk (rclk),
    .rst (rrstn),
    .d   (wgray_q),
    .q   (wgray_rs)
  );

  // Full when the next write pointer sits exactly one lap ahead of the synced read pointer.
  always_comb begin
    wpush          = winc && !wfull_q;
    wbin_d         = wbin_q + PW'(wpush);
    wgray_d        = PW'(bin2gray(ptr_t'(wbin_d)));
    rbin_ws        = PW'(gray2bin(ptr_t'(rgray_ws)));
    wlevel_d       = wbin_d - rbin_ws;
    wfull_d        = (wgray_d == {~rgray_ws[AW:AW-1], rgray_ws[AW-2:0]});
    walmost_full_d = (wlevel_d >= PW'(AF_LEVEL));
    woverflow_d    = winc && wfull_q;
  end

  always_ff @(posedge wclk or posedge wrstn) begin
    if (wrstn) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  always_ff @(posedge wclk) begin
    if (wpush) begin
      mem[wbin_q[AW-1:0]] <= wdata;
    end
  end

  always_comb begin
    rpop            = rinc && !rempty_q;
    rbin_d          = rbin_q + PW'(rpop);
    rgray_d         = PW'(bin2gray(ptr_t'(rbin_d)));
    wbin_rs         = PW'(gray2bin(ptr_t'(wgray_rs)));
    rlevel_d        = wbin_rs - rbin_d;
    rempty_d        = (rgray_d == wgray_rs);
    ralmost_empty_d = (rlevel_d <= PW'(AE_LEVEL));
    runderflow_d    = rinc && rempty_q;
    rdata_d         = rpop ? mem[rbin_q[AW-1:0]] : rdata_q;
  end

  always_ff @(posedge rclk or posedge rrstn) begin
    if (rrstn) begin
      rbin_q          <= '0;
      rgray_q         <= '0;
      rlevel_q        <= '0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      runderflow_q    <= 1'b0;
      rdata_q         <= '0;
    end else begin
      rbin_q          <= rbin_d;
      rgray_q         <= rgray_d;
      rlevel_q        <= rlevel_d;
      rempty_q        <= rempty_d;
      ralmost_empty_q <= ralmost_empty_d;
      runderflow_q    <= runderflow_d;
      rdata_q         <= rdata_d;
    end
  end

  assign wfull         = wfull_q;
  assign walmost_full  = walmost_full_q;
  assign wlevel        = wlevel_q;
  assign woverflow     = woverflow_q;
  assign rdata         = rdata_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = ralmost_empty_q;
  assign rlevel        = rlevel_q;
  assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_async_fifo_level.sv
// Directed and random two-clock traffic against async_fifo_level with a word scoreboard.
// Half periods are in simulator time units; 50:135 approximates 100 MHz : 37 MHz.
module tb_async_fifo_level;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int MAX_CYC = 40000;

  logic             wclk = 1'b0;
  logic             rclk = 1'b0;
  logic             wrstn, rrstn, winc, rinc;
  logic [WIDTH-1:0] wdata, rdata;
  logic             wfull, walmost_full, woverflow;
  logic             rempty, ralmost_empty, runderflow;
  logic [4:0]       wlevel, rlevel;

  int whp = 50;
  int rhp = 135;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] sb [$];

  async_fifo_level #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2),
    .AF_LEVEL    (DEPTH - 2),
    .AE_LEVEL    (2)
  ) dut (
    .wclk          (wclk),
    .wrstn         (wrstn),
    .winc          (winc),
    .wdata         (wdata),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .wlevel        (wlevel),
    .woverflow     (woverflow),
    .rclk          (rclk),
    .rrstn         (rrstn),
    .rinc          (rinc),
    .rdata         (rdata),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  always #(whp) wclk = ~wclk;
  always #(rhp) rclk = ~rclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One write-side cycle; the word is expected at the read side only if the FIFO was not full.
  task automatic applyStimulus(input logic [WIDTH-1:0] data);
    @(negedge wclk);
    winc  = 1'b1;
    wdata = data;
    if (!wfull) sb.push_back(data);
    @(posedge wclk);
    #1;
    winc = 1'b0;
  endtask

  task automatic readStep(output logic accepted);
    logic [WIDTH-1:0] exp;
    exp = '0;
    @(negedge rclk);
    rinc     = 1'b1;
    accepted = !rempty;
    if (accepted) begin
      checkOutput("read_has_data", sb.size() != 0, 1);
      if (sb.size() != 0) exp = sb.pop_front();
    end
    @(posedge rclk);
    #1;
    rinc = 1'b0;
    if (accepted) checkOutput("rdata", rdata, exp);
  endtask

  task automatic waitRempty(input logic level, input int max_edges, output int edges);
    edges = 0;
    while (rempty !== level && edges < max_edges) begin
      @(posedge rclk);
      #1;
      edges++;
    end
  endtask

  // Free-running writer and reader; the reader drains everything queued, including prefill.
  task automatic runTraffic(input int nwords, input int wpct, input int rpct);
    int wdone;
    int rdone;
    int target;
    wdone  = 0;
    rdone  = 0;
    target = sb.size() + nwords;
    fork
      begin
        for (int c = 0; c < MAX_CYC && wdone < nwords; c++) begin
          @(negedge wclk);
          winc  = ($urandom_range(99) < wpct);
          wdata = WIDTH'($urandom);
          if (winc && !wfull) begin
            checkOutput("no_overwrite", sb.size() < DEPTH, 1);
            sb.push_back(wdata);
            wdone++;
          end
        end
        @(negedge wclk);
        winc = 1'b0;
      end
      begin
        logic             pend;
        logic [WIDTH-1:0] exp;
        pend = 1'b0;
        exp  = '0;
        for (int c = 0; c < MAX_CYC; c++) begin
          @(negedge rclk);
          if (pend) begin
            checkOutput("traffic_rdata", rdata, exp);
            pend = 1'b0;
          end
          if (rdone >= target) break;
          rinc = ($urandom_range(99) < rpct);
          if (rinc && !rempty) begin
            checkOutput("read_has_data", sb.size() != 0, 1);
            if (sb.size() != 0) exp = sb.pop_front();
            pend = 1'b1;
            rdone++;
          end
        end
        rinc = 1'b0;
      end
    join
    checkOutput("traffic_writes_done", wdone, nwords);
    checkOutput("traffic_reads_done", rdone, target);
  endtask

  initial begin
    logic acc;
    int   edges;
    logic [WIDTH-1:0] held;

    wrstn = 1'b1;
    rrstn = 1'b1;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = '0;
    #1000;
    checkOutput("reset_wfull", wfull, 0);
    checkOutput("reset_walmost_full", walmost_full, 0);
    checkOutput("reset_wlevel", wlevel, 0);
    checkOutput("reset_woverflow", woverflow, 0);
    checkOutput("reset_rempty", rempty, 1);
    checkOutput("reset_ralmost_empty", ralmost_empty, 1);
    checkOutput("reset_rlevel", rlevel, 0);
    checkOutput("reset_runderflow", runderflow, 0);
    checkOutput("reset_rdata", rdata, 0);
    @(negedge wclk);
    wrstn = 1'b0;
    rrstn = 1'b0;
    repeat (4) @(posedge rclk);

    // Fill to the brim, watching the level and both write-side flags each cycle.
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(WIDTH'(i));
      checkOutput("fill_wlevel", wlevel, i);
      checkOutput("fill_walmost_full", walmost_full, (i >= DEPTH - 2));
      checkOutput("fill_wfull", wfull, (i == DEPTH));
    end

    applyStimulus(8'hFF);
    checkOutput("overflow_pulse", woverflow, 1);
    checkOutput("overflow_wlevel", wlevel, DEPTH);
    checkOutput("overflow_wfull", wfull, 1);
    @(posedge wclk);
    #1;
    checkOutput("overflow_pulse_end", woverflow, 0);

    repeat (4) @(posedge rclk);
    #1;
    checkOutput("full_rlevel", rlevel, DEPTH);
    for (int i = 1; i <= DEPTH; i++) begin
      readStep(acc);
      checkOutput("drain_accepted", acc, 1);
      checkOutput("drain_rlevel", rlevel, DEPTH - i);
      checkOutput("drain_ralmost_empty", ralmost_empty, (DEPTH - i <= 2));
      checkOutput("drain_rempty", rempty, (i == DEPTH));
    end
    repeat (6) @(posedge wclk);
    #1;
    checkOutput("drained_wfull", wfull, 0);
    checkOutput("drained_wlevel", wlevel, 0);
    checkOutput("drained_walmost_full", walmost_full, 0);

    held = rdata;
    readStep(acc);
    checkOutput("underflow_not_accepted", acc, 0);
    checkOutput("underflow_pulse", runderflow, 1);
    checkOutput("underflow_rdata_hold", rdata, held);
    checkOutput("underflow_rlevel", rlevel, 0);
    @(posedge rclk);
    #1;
    checkOutput("underflow_pulse_end", runderflow, 0);

    applyStimulus(8'hA5);
    waitRempty(1'b0, 4, edges);
    checkOutput("single_rempty_deassert", rempty, 0);
    readStep(acc);
    checkOutput("single_accepted", acc, 1);

    // Simultaneous traffic starting from the one-entry and DEPTH-1 states.
    applyStimulus(8'h33);
    waitRempty(1'b0, 8, edges);
    runTraffic(64, 100, 100);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(WIDTH'(8'h40 + i));
    repeat (6) @(posedge rclk);
    runTraffic(64, 100, 100);

    whp = 15;
    rhp = 35;
    runTraffic(5000, 40, 90);
    whp = 35;
    rhp = 15;
    runTraffic(5000, 90, 40);
    whp = 50;
    rhp = 135;

    for (int i = 0; i < 9; i++) applyStimulus(WIDTH'(8'h90 + i));
    repeat (6) @(posedge rclk);
    #1;
    checkOutput("midstream_rlevel", rlevel, 9);
    wrstn = 1'b1;
    rrstn = 1'b1;
    #1;
    sb.delete();
    checkOutput("flush_wfull", wfull, 0);
    checkOutput("flush_walmost_full", walmost_full, 0);
    checkOutput("flush_wlevel", wlevel, 0);
    checkOutput("flush_woverflow", woverflow, 0);
    checkOutput("flush_rempty", rempty, 1);
    checkOutput("flush_ralmost_empty", ralmost_empty, 1);
    checkOutput("flush_rlevel", rlevel, 0);
    checkOutput("flush_runderflow", runderflow, 0);
    checkOutput("flush_rdata", rdata, 0);
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    wrstn = 1'b0;
    rrstn = 1'b0;
    repeat (4) @(posedge rclk);
    applyStimulus(8'h5A);
    waitRempty(1'b0, 4, edges);
    checkOutput("post_flush_rempty", rempty, 0);
    readStep(acc);
    checkOutput("post_flush_accepted", acc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
